wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back collector sitting directly upstream of the bypass buffer in the TPU backend. It merges result streams from two execution pipes, A (ALU) and B (memory access), into the single write-back index/data stream consumed by the bypass buffer and register file. Each source has its own small FIFO. The block grants one entry per cycle with round-robin fairness and honours the bypass buffer's full flag.

## Interface
- FIFO_DEPTH, 4, entries per source FIFO; power of two, ≥ 2
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- I_Full  in  1  downstream (bypass buffer) full; blocks grant
- I_WB_Index_A  in  dst_t  pipe A write-back index; `.v` = push request
- I_WB_Data_A  in  data_t  pipe A write-back data
- I_WB_Index_B  in  dst_t  pipe B write-back index; `.v` = push request
- I_WB_Data_B  in  data_t  pipe B write-back data
- O_Stall_A  out  1  backpressure to pipe A
- O_Stall_B  out  1  backpressure to pipe B
- O_WB_Index  out  dst_t  merged write-back index; `.v` marks a valid beat
- O_WB_Data  out  data_t  merged write-back data
- O_Empty  out  1  both FIFOs empty and output register invalid
- O_Err  out  1  sticky overflow flag

## Operation
- Push: `I_WB_Index_x.v=1` writes `{index, data}` into FIFO x at the clock edge.
- Grant:
  - A grant happens only when `I_Full=0` and at least one FIFO is non-empty.
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, the FIFO not granted last time wins.
  - The round-robin state is a 1-bit `last_grant` register; after reset it favours A.
- Output register: a granted head pops and loads `O_WB_Index`/`O_WB_Data` with `.v=1`. Without a grant, `O_WB_Index.v` is loaded 0 and `O_WB_Data` holds its previous value.
- Stalled cycle: when `I_Full=1`, there is no pop and `last_grant` is unchanged.
- Backpressure: `O_Stall_x = (count_x >= FIFO_DEPTH-1)`, combinational from the registered count. The one spare entry absorbs a push issued in the cycle the stall rises.
- Overflow: a push to a full FIFO with no simultaneous pop is dropped, and `O_Err` is set until reset.
- Full FIFO, push and pop in the same cycle: legal; count is unchanged and no error is raised.
- Ordering:
  - Strict FIFO order within each source.
  - No ordering between sources; WAW hazards across pipes are excluded by the upstream scoreboard.

## Timing
- Reset values: `O_WB_Index='0`, `O_WB_Data='0`, `O_Stall_A=O_Stall_B=0`, `O_Empty=1`, `O_Err=0`, both FIFOs empty, `last_grant` favouring A.
- Reset mid-operation: all pending entries are discarded immediately, without waiting for a clock edge.
- Latency: a push sampled at edge k appears on `O_WB_*` after edge k+1, provided the FIFO was empty, `I_Full=0` and the source wins arbitration. There is no combinational fast path.
- Throughput: one write-back per cycle sustained while `I_Full=0`.
- `O_WB_Index.v` is high for exactly one cycle per granted entry.
- `I_Full` is sampled in the grant cycle; a beat already in the output register is not retracted.
- Counts are `$clog2(FIFO_DEPTH)+1` bits; read/write pointers wrap modulo `FIFO_DEPTH`.

## Structure
- `dst_t` (with `.v`, `.idx`) and `data_t` come from `pkg_tpu`; no new package types.
- Sub-module `wb_fifo`, instantiated twice:
  - Parameterised depth.
  - Push/pop ports, head `{dst_t, data_t}` output, count output.
  - Registered pointers and count.
  - Asynchronous active-low reset.
- Top level contains the arbiter, `last_grant`, the output register, stall/empty/error logic.

## Test plan
- Single A push, idx=5, data=0xDEAD, at cycle 0 with `I_Full=0` → `O_WB_Index.idx=5`, `.v=1`, data 0xDEAD at cycle 2, valid one cycle only. `O_Empty` returns to 1 at cycle 3.
- A pushes idx 1,2,3 and B pushes idx 9,10,11 on the same cycles, after reset → output sequence 1,9,2,10,3,11 on consecutive cycles.
- Three A entries pending while `I_Full=1` for 3 cycles → no valid beats during the stall, and `last_grant` is unchanged. After deassertion, 1,2,3 emerge on consecutive cycles with none lost.
- `FIFO_DEPTH=4`, `I_Full=1`, A pushes on 5 consecutive cycles:
  - `O_Stall_A=1` once the count reaches 3.
  - The 4th push is stored.
  - The 5th push is dropped and `O_Err=1` stays set.
  - After `I_Full` drops, exactly 4 entries drain in order.
- Full FIFO A with simultaneous push and pop while `I_Full=0` → count stays 4, `O_Err` stays 0, order is preserved.
- `reset` asserted low mid-stream with both FIFOs holding entries → all outputs take reset values without a clock edge. After release, a B push of idx=7 emerges 2 cycles later, and no stale entries appear.

Source files
------------

// File: rtl/pkg_tpu.sv
// Shared TPU backend types: write-back destination descriptor and data word.
package pkg_tpu;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } dst_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source write-back FIFO: registered pointers/count, head exposed combinationally.
module wb_fifo
  import pkg_tpu::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  dst_t                   push_dst,
  input  data_t                  push_data,
  input  logic                   pop,
  output dst_t                   head_dst,
  output data_t                  head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] idx_mem_q  [DEPTH];
  logic [IDX_W-1:0] idx_mem_d  [DEPTH];
  data_t            data_mem_q [DEPTH];
  data_t            data_mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_s  = pop && (count_q != {CW{1'b0}});
  assign do_push_s = push && ((count_q != FULL_LVL) || do_pop_s);
  assign overflow  = push && !do_push_s;

  assign head_dst.v   = (count_q != {CW{1'b0}});
  assign head_dst.idx = idx_mem_q[rd_ptr_q];
  assign head_data    = data_mem_q[rd_ptr_q];
  assign count        = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    idx_mem_d  = idx_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push_s) begin
      idx_mem_d[wr_ptr_q]  = push_dst.idx;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_mem_q  <= '{default: '0};
      data_mem_q <= '{default: '0};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      idx_mem_q  <= idx_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU (A) and memory (B) write-back streams into one registered stream
// with round-robin arbitration, backpressure and sticky overflow reporting.
module wb_arbiter
  import pkg_tpu::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  I_Full,
  input  dst_t  I_WB_Index_A,
  input  data_t I_WB_Data_A,
  input  dst_t  I_WB_Index_B,
  input  data_t I_WB_Data_B,
  output logic  O_Stall_A,
  output logic  O_Stall_B,
  output dst_t  O_WB_Index,
  output data_t O_WB_Data,
  output logic  O_Empty,
  output logic  O_Err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 1);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e          last_grant_q, last_grant_d;
  dst_t          out_dst_q, out_dst_d;
  data_t         out_data_q, out_data_d;
  logic          err_q, err_d;
  logic          pop_a_s, pop_b_s;
  logic          ovf_a_s, ovf_b_s;
  dst_t          head_a_s, head_b_s;
  data_t         head_data_a_s, head_data_b_s;
  logic [CW-1:0] count_a_s, count_b_s;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock     (clock),
    .reset     (reset),
    .push      (I_WB_Index_A.v),
    .push_dst  (I_WB_Index_A),
    .push_data (I_WB_Data_A),
    .pop       (pop_a_s),
    .head_dst  (head_a_s),
    .head_data (head_data_a_s),
    .count     (count_a_s),
    .overflow  (ovf_a_s)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock     (clock),
    .reset     (reset),
    .push      (I_WB_Index_B.v),
    .push_dst  (I_WB_Index_B),
    .push_data (I_WB_Data_B),
    .pop       (pop_b_s),
    .head_dst  (head_b_s),
    .head_data (head_data_b_s),
    .count     (count_b_s),
    .overflow  (ovf_b_s)
  );

  // Grant selection: with both heads pending, the source not served last wins.
  always_comb begin
    pop_a_s = 1'b0;
    pop_b_s = 1'b0;
    if (!I_Full) begin
      case ({head_a_s.v, head_b_s.v})
        2'b10: pop_a_s = 1'b1;
        2'b01: pop_b_s = 1'b1;
        2'b11: begin
          if (last_grant_q == SRC_B) begin
            pop_a_s = 1'b1;
          end else begin
            pop_b_s = 1'b1;
          end
        end
        default: begin
          pop_a_s = 1'b0;
          pop_b_s = 1'b0;
        end
      endcase
    end else begin
      pop_a_s = 1'b0;
      pop_b_s = 1'b0;
    end
  end

  // Output register and round-robin state; data holds when no beat is issued.
  always_comb begin
    out_dst_d    = out_dst_q;
    out_dst_d.v  = 1'b0;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | ovf_a_s | ovf_b_s;
    if (pop_a_s) begin
      out_dst_d    = head_a_s;
      out_dst_d.v  = 1'b1;
      out_data_d   = head_data_a_s;
      last_grant_d = SRC_A;
    end else if (pop_b_s) begin
      out_dst_d    = head_b_s;
      out_dst_d.v  = 1'b1;
      out_data_d   = head_data_b_s;
      last_grant_d = SRC_B;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Registers; reset leaves last_grant on B so A wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= SRC_B;
      out_dst_q    <= '0;
      out_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      out_dst_q    <= out_dst_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

  assign O_WB_Index = out_dst_q;
  assign O_WB_Data  = out_data_q;
  assign O_Err      = err_q;
  assign O_Stall_A  = (count_a_s >= STALL_LVL);
  assign O_Stall_B  = (count_b_s >= STALL_LVL);
  assign O_Empty    = (count_a_s == {CW{1'b0}}) && (count_b_s == {CW{1'b0}}) && !out_dst_q.v;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_wb_arbiter;
  import pkg_tpu::*;

  localparam int DEPTH = 4;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  logic  I_Full = 1'b0;
  dst_t  ia = '0;
  dst_t  ib = '0;
  data_t da = '0;
  data_t db = '0;
  logic  O_Stall_A, O_Stall_B, O_Empty, O_Err;
  dst_t  O_WB_Index;
  data_t O_WB_Data;

  always #5 clock = ~clock;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Full       (I_Full),
    .I_WB_Index_A (ia),
    .I_WB_Data_A  (da),
    .I_WB_Index_B (ib),
    .I_WB_Data_B  (db),
    .O_Stall_A    (O_Stall_A),
    .O_Stall_B    (O_Stall_B),
    .O_WB_Index   (O_WB_Index),
    .O_WB_Data    (O_WB_Data),
    .O_Empty      (O_Empty),
    .O_Err        (O_Err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int got[$];
  int got_cyc[$];

  typedef struct {
    logic [IDX_W-1:0] idx;
    data_t            data;
  } ent_t;

  ent_t             qa[$];
  ent_t             qb[$];
  logic             m_last_b;
  logic             exp_v;
  logic [IDX_W-1:0] exp_idx;
  data_t            exp_data;
  logic             exp_err;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    m_last_b = 1'b1;
    exp_v    = 1'b0;
    exp_idx  = '0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  task automatic model_step();
    int   sa;
    int   sb;
    logic took_a;
    logic took_b;
    ent_t e;
    sa     = qa.size();
    sb     = qb.size();
    took_a = 1'b0;
    took_b = 1'b0;
    exp_v  = 1'b0;
    if (!I_Full && (sa > 0 || sb > 0)) begin
      if (sa > 0 && (sb == 0 || m_last_b)) begin
        e = qa.pop_front();
        took_a = 1'b1;
        m_last_b = 1'b0;
      end else begin
        e = qb.pop_front();
        took_b = 1'b1;
        m_last_b = 1'b1;
      end
      exp_v    = 1'b1;
      exp_idx  = e.idx;
      exp_data = e.data;
    end
    if (ia.v) begin
      if (sa < DEPTH || took_a) begin
        e.idx = ia.idx; e.data = da; qa.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (ib.v) begin
      if (sb < DEPTH || took_b) begin
        e.idx = ib.idx; e.data = db; qb.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        cyc++;
        chk("cmp_v", O_WB_Index.v, exp_v);
        if (exp_v) chk("cmp_idx", O_WB_Index.idx, exp_idx);
        chk("cmp_data", O_WB_Data, exp_data);
        chk("cmp_stall_a", O_Stall_A, qa.size() >= DEPTH - 1);
        chk("cmp_stall_b", O_Stall_B, qb.size() >= DEPTH - 1);
        chk("cmp_empty", O_Empty, (qa.size() == 0) && (qb.size() == 0) && !exp_v);
        chk("cmp_err", O_Err, exp_err);
        if (O_WB_Index.v) begin
          got.push_back(int'(O_WB_Index.idx));
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pa, input int xa, input logic pb, input int xb, input logic f);
    ia.v   = pa;
    ia.idx = IDX_W'(xa);
    da     = 32'h0000_A000 | 32'(xa);
    ib.v   = pb;
    ib.idx = IDX_W'(xb);
    db     = 32'h0000_B000 | 32'(xb);
    I_Full = f;
  endtask

  task automatic idle(input int n, input logic f);
    drive(1'b0, 0, 1'b0, 0, f);
    repeat (n) tick();
  endtask

  task automatic reset_dut();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  task automatic check_seq(input string name, input int n, input int e[8]);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        chk({name, "_idx"}, got[i], e[i]);
        if (i > 0) chk({name, "_gap"}, got_cyc[i] - got_cyc[i-1], 1);
      end
    end
  endtask

  initial begin
    int e2[8] = '{1, 9, 2, 10, 3, 11, 0, 0};
    int e3[8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int e4[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int e5[8] = '{1, 2, 3, 4, 5, 6, 0, 0};
    int e6[8] = '{7, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) tick();
    chk("rst_empty", O_Empty, 1);
    chk("rst_v", O_WB_Index.v, 0);
    chk("rst_data", O_WB_Data, 0);
    reset = 1'b1;

    // single push latency
    reset_dut();
    drive(1'b1, 5, 1'b0, 0, 1'b0);
    da = 32'h0000_DEAD;
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    chk("t1_empty_c1", O_Empty, 0);
    chk("t1_v_c1", O_WB_Index.v, 0);
    tick();
    chk("t1_v_c2", O_WB_Index.v, 1);
    chk("t1_idx_c2", O_WB_Index.idx, 5);
    chk("t1_data_c2", O_WB_Data, 32'h0000_DEAD);
    chk("t1_model_v", exp_v, 1);
    tick();
    chk("t1_v_c3", O_WB_Index.v, 0);
    chk("t1_empty_c3", O_Empty, 1);
    chk("t1_hold_c3", O_WB_Data, 32'h0000_DEAD);

    // round-robin interleave
    reset_dut();
    drive(1'b1, 1, 1'b1, 9, 1'b0);  tick();
    drive(1'b1, 2, 1'b1, 10, 1'b0); tick();
    drive(1'b1, 3, 1'b1, 11, 1'b0); tick();
    idle(6, 1'b0);
    check_seq("t2_rr", 6, e2);

    // stall holds everything
    reset_dut();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 1'b0, 0, 1'b1);
      tick();
    end
    idle(3, 1'b1);
    chk("t3_no_beat", got.size(), 0);
    idle(5, 1'b0);
    check_seq("t3_drain", 3, e3);

    // overflow
    reset_dut();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, i, 1'b0, 0, 1'b1);
      tick();
      if (i == 2) chk("t4_stall_at2", O_Stall_A, 0);
      if (i == 3) chk("t4_stall_at3", O_Stall_A, 1);
      if (i == 4) chk("t4_err_at4", O_Err, 0);
      if (i == 5) chk("t4_err_at5", O_Err, 1);
    end
    idle(2, 1'b1);
    chk("t4_err_sticky", O_Err, 1);
    idle(6, 1'b0);
    check_seq("t4_drain", 4, e4);
    chk("t4_err_end", O_Err, 1);
    chk("t4_stall_end", O_Stall_A, 0);

    // full FIFO with simultaneous push and pop
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b0, 0, 1'b1);
      tick();
    end
    chk("t5_stall_full", O_Stall_A, 1);
    drive(1'b1, 5, 1'b0, 0, 1'b0); tick();
    chk("t5_err_a", O_Err, 0);
    chk("t5_stall_a", O_Stall_A, 1);
    drive(1'b1, 6, 1'b0, 0, 1'b0); tick();
    chk("t5_err_b", O_Err, 0);
    idle(6, 1'b0);
    check_seq("t5_order", 6, e5);
    chk("t5_err_end", O_Err, 0);

    // asynchronous reset mid-stream
    reset_dut();
    drive(1'b1, 1, 1'b1, 9, 1'b1); tick();
    drive(1'b1, 2, 1'b0, 0, 1'b1); tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0); tick();
    chk("t6_pre_v", O_WB_Index.v, 1);
    chk("t6_pre_idx", O_WB_Index.idx, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_v", O_WB_Index.v, 0);
    chk("t6_rst_idx", O_WB_Index.idx, 0);
    chk("t6_rst_data", O_WB_Data, 0);
    chk("t6_rst_stall_a", O_Stall_A, 0);
    chk("t6_rst_stall_b", O_Stall_B, 0);
    chk("t6_rst_empty", O_Empty, 1);
    chk("t6_rst_err", O_Err, 0);
    got.delete();
    got_cyc.delete();
    #3 reset = 1'b1;
    drive(1'b0, 0, 1'b1, 7, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    chk("t6_v_c1", O_WB_Index.v, 0);
    tick();
    chk("t6_v_c2", O_WB_Index.v, 1);
    chk("t6_idx_c2", O_WB_Index.idx, 7);
    chk("t6_data_c2", O_WB_Data, 32'h0000_B007);
    idle(5, 1'b0);
    check_seq("t6_fresh", 1, e6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
